tug_field: RTL

- Game-side responder to the master controller (MC).
- Consumes MC's clear / leds_on / led_control and player push-button edges; produces MC's winrnd and rout inputs.
- Tracks rope position on an N-LED bar, detects round wins and Dark-phase fouls, and times the random Dark interval with an LFSR.
- Keeps per-player round scores and drives the LED bar.

---
 rtl/tug_field.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/tug_field.sv
// -----------------------------------------------------------------------------
// tug_field
//   Game-side responder for the tug-of-war master controller (MC). It follows
//   the MC phase signals, tracks the rope position on an N_POS-LED bar, detects
//   round wins and Dark-phase fouls, and times a random Dark interval with an
//   8-bit LFSR. It also keeps the per-player round scores.
//
//   No valid/ready handshakes are involved. The MC link is level based.
//   winrnd is a single-clk pulse that the MC samples on its own clock.
//   rout is a level that stays high while the Dark timer has expired.
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous, active-low reset
//   slowen       in   one-clk slow tick (the same tick the MC sees)
//   leftp        in   left player button, debounced synchronous level
//   rightp       in   right player button, debounced synchronous level
//   clear        in   from MC, 1 = no round in progress
//   leds_on      in   from MC, 0 = Dark state
//   led_control  in   from MC, bit0 = 1 in RESET/Wait, bit1 = 0 only in Dark
//   winrnd       out  one-clk pulse, round decided
//   rout         out  level, random Dark interval has expired
//   leds         out  LED bar, bit 0 = left end
//   score_l      out  rounds won by the left player (saturates at 15)
//   score_r      out  rounds won by the right player (saturates at 15)
// -----------------------------------------------------------------------------
module tug_field #(
    parameter int         N_POS     = 9,
    parameter int         MIN_DARK  = 2,
    parameter logic [7:0] DARK_MASK = 8'h07
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             slowen,
    input  logic             leftp,
    input  logic             rightp,
    input  logic             clear,
    input  logic             leds_on,
    input  logic [1:0]       led_control,
    output logic             winrnd,
    output logic             rout,
    output logic [N_POS-1:0] leds,
    output logic [3:0]       score_l,
    output logic [3:0]       score_r
);

    localparam int             PW     = $clog2(N_POS);
    localparam logic [PW-1:0]  CENTER = PW'((N_POS - 1) / 2);
    localparam logic [PW-1:0]  LAST   = PW'(N_POS - 1);

    logic [PW-1:0] pos;
    logic          lock;
    logic [8:0]    dark_cnt;
    logic [8:0]    dark_cnt_next;
    logic [7:0]    lfsr;
    logic          left_q;
    logic          right_q;
    logic          leds_on_q;

    logic le;
    logic re;
    logic setup;
    logic dark;
    logic play;
    logic dark_entry;
    logic one_press;

    // Press events are rising edges of the button levels.
    assign le = leftp & ~left_q;
    assign re = rightp & ~right_q;

    // MC phase decode. A round is in progress only while clear=0.
    assign setup      = clear & led_control[0];
    assign dark       = ~clear & ~leds_on & ~led_control[1];
    assign play       = ~clear & leds_on;
    assign dark_entry = dark & leds_on_q;
    // If both buttons rise in the same clk, the presses cancel out.
    assign one_press  = le ^ re;

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s == 4'd15) ? s : s + 4'd1;
    endfunction

    // The Dark timer loads on entry and then counts slowen ticks down to zero.
    always_comb begin
        dark_cnt_next = dark_cnt;
        if (dark_entry)
            dark_cnt_next = 9'(MIN_DARK) + {1'b0, lfsr & DARK_MASK};
        else if (dark && slowen && (dark_cnt != 9'd0))
            dark_cnt_next = dark_cnt - 9'd1;
    end

    // Free-running LFSR, input history, Dark timer and rout.
    // The LFSR polynomial is x^8+x^6+x^5+x^4+1. It is seeded with a nonzero
    // value, so it never reaches the all-zero lock-up state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr      <= 8'hA5;
            left_q    <= 1'b0;
            right_q   <= 1'b0;
            leds_on_q <= 1'b0;
            dark_cnt  <= 9'd0;
            rout      <= 1'b0;
        end else begin
            lfsr      <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            left_q    <= leftp;
            right_q   <= rightp;
            leds_on_q <= leds_on;
            dark_cnt  <= dark_cnt_next;
            // Registered so rout is clean. It drops one clk after Dark ends.
            rout      <= dark & ~dark_entry & (dark_cnt_next == 9'd0);
        end
    end

    // Rope position, lock, scores and the win pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos     <= CENTER;
            lock    <= 1'b0;
            score_l <= 4'd0;
            score_r <= 4'd0;
            winrnd  <= 1'b0;
        end else begin
            winrnd <= 1'b0;
            if (setup) begin
                pos     <= CENTER;
                lock    <= 1'b0;
                score_l <= 4'd0;
                score_r <= 4'd0;
            end else if (dark_entry) begin
                // The winner's end stayed lit through Gloat. Recentre now.
                // Presses on this clk are ignored.
                if ((pos == '0) || (pos == LAST))
                    pos <= CENTER;
                lock <= 1'b0;
            end else if (dark && !lock && one_press) begin
                // Foul: the opponent of the early presser wins the round.
                if (le) begin
                    pos     <= LAST;
                    score_r <= sat_inc(score_r);
                end else begin
                    pos     <= '0;
                    score_l <= sat_inc(score_l);
                end
                winrnd <= 1'b1;
                lock   <= 1'b1;
            end else if (play && !lock && one_press) begin
                if (le) begin
                    if (pos != '0) begin
                        pos <= pos - 1'b1;
                        if (pos == PW'(1)) begin
                            score_l <= sat_inc(score_l);
                            winrnd  <= 1'b1;
                            lock    <= 1'b1;
                        end
                    end
                end else begin
                    if (pos != LAST) begin
                        pos <= pos + 1'b1;
                        if (pos == LAST - 1'b1) begin
                            score_r <= sat_inc(score_r);
                            winrnd  <= 1'b1;
                            lock    <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // LED bar: dark, all lit during RESET/Wait, otherwise the rope marker.
    assign leds = !leds_on        ? '0 :
                  led_control[0]  ? '1 :
                  (N_POS'(1) << pos);

endmodule
